vga_scan_controller: RTL and testbench
======================================

Name: vga_scan_controller

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25.175 MHz pixel clock.
- Drives the linear pixel address (y*640+x) into the screen processor that resolves sprite/text/palette indices, and accepts back the resolved 24-bit colour from the palette lookup.
- Re-aligns sync and blank to the processor/ROM pipeline latency, then drives the DAC pins.
- Supplies a once-per-frame strobe for game-logic updates.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BACK, 48, horizontal back porch
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BACK, 33, vertical back porch
PIPE_LAT, 2, cycles from oAddress to matching iColor; legal range 1..4

Ports:
iVGA_CLK  in  1  pixel clock; all logic on rising edge
iRST_n  in  1  synchronous active-low reset
oAddress  out  19  linear pixel address to screen processor
iColor  in  24  {R[23:16],G[15:8],B[7:0]} for address issued PIPE_LAT cycles earlier
oVGA_R  out  8  red to DAC
oVGA_G  out  8  green to DAC
oVGA_B  out  8  blue to DAC
oVGA_HS  out  1  horizontal sync, active low
oVGA_VS  out  1  vertical sync, active low
oVGA_BLANK_n  out  1  high during visible pixels
oFrameStart  out  1  one-cycle pulse at start of vertical blanking

Behaviour:
- Clocking and reset: one clock, iVGA_CLK. Reset iRST_n is synchronous and active-low.
- Reset values when iRST_n=0 at a clock edge:
  - hcount=0, vcount=0, oAddress=0
  - oVGA_R/G/B=0, oVGA_HS=1, oVGA_VS=1, oVGA_BLANK_n=0, oFrameStart=0
  - all delay-line stages loaded with the inactive tuple (hs=1, vs=1, blank_n=0)
  - Mid-frame reset restarts the raster at (0,0) on the next cycle.
- hcount: 0..H_TOTAL-1, H_TOTAL = sum of H params = 800. Wraps to 0 and increments vcount.
- vcount: 0..V_TOTAL-1, V_TOTAL = 525. Wraps to 0 after (799,524).
- Region order per axis: visible, front porch, sync, back porch.
  - visible = hcount<640 && vcount<480.
  - raw hs low for 656<=hcount<752.
  - raw vs low for 490<=vcount<492 (whole lines).
- oAddress is a registered counter; no multiplier.
  - Equals vcount*640+hcount while visible.
  - Increments by 1 per visible pixel.
  - Outside the visible region it holds the address of the next visible pixel: next line start during horizontal blank; 0 from (640,479) through end of frame.
  - Maximum value 307199; must never exceed it.
- Alignment pipeline: raw {hs,vs,visible} enters a PIPE_LAT-deep delay line. iColor is sampled in the same cycle as the delay-line output.
- Output register stage:
  - oVGA_HS/VS = delayed hs/vs.
  - oVGA_BLANK_n = delayed visible.
  - oVGA_R/G/B = iColor fields when delayed visible=1, else 0.
- Total latency from raster position to pins = PIPE_LAT+1 cycles, identical for sync, blank and colour.
- oFrameStart: 1 for exactly the cycle where hcount==0 && vcount==480 (undelayed). Period = 420000 cycles.
- No handshake: iColor is trusted valid every cycle. X on iColor during blank must not reach the pins.

Decomposition:
- Package vga_timing_pkg: the eight timing constants, derived H_TOTAL/V_TOTAL, sync-start/end constants, ADDR_W=19, COLOR_W=24.
- Sub-module vga_delay_line: parameterised width W and depth D shift register with a synchronous active-low reset to a parameterised reset value. Instantiate once with W=3, D=PIPE_LAT.
- Counters, address generator and output register stay in the top.

Test Plan:
- Reset hold 5 cycles, release -> outputs at reset values until cycle PIPE_LAT+1. First oVGA_BLANK_n=1 at cycle PIPE_LAT+1 (3 with default), oAddress=0 at cycle 0.
- Free-run one line -> oVGA_HS low exactly 96 cycles starting at pin cycle 656+3. BLANK_n high 640 cycles per line. Line period 800.
- Address trace -> oAddress=639 at (639,0). Holds 640 across hcount 640..799. Equals 640 at (0,1), 307199 at (639,479), then 0 through vblank. Never >307199.
- Full frame -> oVGA_VS low for exactly 1600 cycles. oFrameStart pulses once, 420000 cycles apart across 3 frames.
- iColor driven 24'hFF8001 constantly -> pins show R=255, G=128, B=1 only while oVGA_BLANK_n=1, else 0. A model with PIPE_LAT=4 shows colour/blank alignment still exact.
- Assert iRST_n=0 for 1 cycle at (300,200) -> next cycle counters (0,0), oAddress=0, pins inactive. The raster restarts cleanly with no partial sync pulse longer than spec.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants and the sync/blank tuple type
package vga_timing_pkg;
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 24;
    localparam int DEFAULT_PIPE_LAT = 2;

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: D-deep, W-wide shift register with a sync active-low reset value
module vga_delay_line #(
    parameter int W = 3,
    parameter int D = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stage [D];

    // advance one stage per clock; reset fills every stage with the idle value
    always_ff @(posedge clk)
        if (!rst_n) begin
            for (int i = 0; i < D; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
        end

    assign q = stage[D-1];
endmodule

// File: rtl/vga_scan_controller.sv
// vga_scan_controller: VGA raster counters, pixel address, sync re-alignment and DAC register
module vga_scan_controller
    import vga_timing_pkg::*;
#(
    parameter int PIPE_LAT = DEFAULT_PIPE_LAT,
    parameter int H_VIS = H_VISIBLE,
    parameter int H_FP  = H_FRONT,
    parameter int H_SW  = H_SYNC,
    parameter int H_BP  = H_BACK,
    parameter int V_VIS = V_VISIBLE,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_BP  = V_BACK
) (
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    output logic [ADDR_W-1:0]  oAddress,
    input  logic [COLOR_W-1:0] iColor,
    output logic [7:0]         oVGA_R,
    output logic [7:0]         oVGA_G,
    output logic [7:0]         oVGA_B,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_BLANK_n,
    output logic               oFrameStart
);
    localparam logic [9:0] H_ACT  = 10'(H_VIS);
    localparam logic [9:0] HS_ON  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_OFF = 10'(H_VIS + H_FP + H_SW);
    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [9:0] V_ACT  = 10'(V_VIS);
    localparam logic [9:0] V_FS   = 10'(V_VIS - 1);
    localparam logic [9:0] VS_ON  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_OFF = 10'(V_VIS + V_FP + V_SW);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(H_VIS * V_VIS - 1);

    logic [9:0] hcount, vcount;
    logic       h_end, v_end;
    sync_t      raw, dly;

    assign h_end = hcount == H_LAST;
    assign v_end = vcount == V_LAST;
    assign raw = '{hs:  !(hcount >= HS_ON && hcount < HS_OFF),
                   vs:  !(vcount >= VS_ON && vcount < VS_OFF),
                   vis: hcount < H_ACT && vcount < V_ACT};

    // raster position: hcount wraps each line, vcount each frame
    always_ff @(posedge iVGA_CLK)
        if (!iRST_n) begin
            hcount <= '0;
            vcount <= '0;
        end else begin
            hcount <= h_end ? '0 : hcount + 10'd1;
            if (h_end) vcount <= v_end ? '0 : vcount + 10'd1;
        end

    // address steps only on visible pixels, so in blanking it already points at the next one
    always_ff @(posedge iVGA_CLK)
        if (!iRST_n) oAddress <= '0;
        else if (raw.vis) oAddress <= oAddress == A_LAST ? '0 : oAddress + ADDR_W'(1);

    // frame strobe lands on the first line of vertical blanking
    always_ff @(posedge iVGA_CLK)
        oFrameStart <= iRST_n && h_end && vcount == V_FS;

    vga_delay_line #(
        .W      (3),
        .D      (PIPE_LAT),
        .RST_VAL(SYNC_IDLE)
    ) u_align (
        .clk  (iVGA_CLK),
        .rst_n(iRST_n),
        .d    (raw),
        .q    (dly)
    );

    // pin register: delayed sync/blank with colour forced to black outside the visible area
    always_ff @(posedge iVGA_CLK)
        if (!iRST_n) begin
            {oVGA_R, oVGA_G, oVGA_B} <= '0;
            oVGA_HS      <= 1'b1;
            oVGA_VS      <= 1'b1;
            oVGA_BLANK_n <= 1'b0;
        end else begin
            {oVGA_R, oVGA_G, oVGA_B} <= dly.vis ? iColor : '0;
            oVGA_HS      <= dly.hs;
            oVGA_VS      <= dly.vs;
            oVGA_BLANK_n <= dly.vis;
        end
endmodule

// File: tb/tb_vga_scan_controller.sv
// tb_vga_scan_controller: scoreboarded directed checks of full-timing and short-frame instances
module tb_vga_scan_controller;
    typedef enum int {S_ADDR, S_HS, S_VS, S_BLANK, S_RGB, S_FS, S_HSFALL, S_HSLEN, S_BLEN,
                      S_RGBBAD, S_VSFALL, S_VSLEN, S_FSPER, S_FSCNT, S_AMAX, S_MBAD} sig_e;
    typedef struct {
        bit    d;
        int    cyc;
        sig_e  s;
        int    val;
        string name;
    } chk_t;

    chk_t q[$];
    int   nchk = 0, nfail = 0;

    logic clk = 0;
    logic rst_n = 0, rst4_n = 0, use_const = 0;
    int   cyc = 0, cyc4 = 0;

    logic [18:0] addr0, addr4;
    logic [23:0] col0, col4;
    logic [7:0]  r0, g0, b0, r4, g4, b4;
    logic        hs0, vs0, bl0, fs0, hs4, vs4, bl4, fs4;
    logic [18:0] pipe0 [2] = '{default: '0};
    logic [18:0] pipe4 [4] = '{default: '0};

    always #20 clk = ~clk;

    function automatic logic [23:0] colf(input logic [18:0] a);
        return {a[7:0], ~a[7:0], a[15:8]};
    endfunction

    assign col0 = use_const ? 24'hFF8001 : colf(pipe0[1]);
    assign col4 = colf(pipe4[3]);

    vga_scan_controller dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .oAddress(addr0), .iColor(col0),
        .oVGA_R(r0), .oVGA_G(g0), .oVGA_B(b0), .oVGA_HS(hs0), .oVGA_VS(vs0),
        .oVGA_BLANK_n(bl0), .oFrameStart(fs0)
    );

    vga_scan_controller #(.PIPE_LAT(4), .V_VIS(4), .V_FP(2), .V_SW(2), .V_BP(2)) dut4 (
        .iVGA_CLK(clk), .iRST_n(rst4_n), .oAddress(addr4), .iColor(col4),
        .oVGA_R(r4), .oVGA_G(g4), .oVGA_B(b4), .oVGA_HS(hs4), .oVGA_VS(vs4),
        .oVGA_BLANK_n(bl4), .oFrameStart(fs4)
    );

    // screen-processor stand-ins and cycle counters (cycle 0 = first cycle out of reset)
    always @(posedge clk) begin
        pipe0[0] <= addr0;
        pipe0[1] <= pipe0[0];
        pipe4[0] <= addr4;
        for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
        cyc  <= rst_n ? cyc + 1 : 0;
        cyc4 <= rst4_n ? cyc4 + 1 : 0;
    end

    logic hs_prev = 1, bl_prev = 0, vs_prev = 1;
    int   hs_fall = 0, hs_len = 0, bl_rise = 0, bl_len = 0, rgb_bad = 0;
    int   vs_fall = 0, vs_len = 0, fs_last = -1, fs_per = 0, fs_cnt = 0, amax = 0, mbad = 0;

    // pin-level measurements on the full-timing instance
    always @(negedge clk)
        if (rst_n) begin
            if (!hs0 && hs_prev) hs_fall <= cyc;
            if (hs0 && !hs_prev) hs_len <= cyc - hs_fall;
            if (bl0 && !bl_prev) bl_rise <= cyc;
            if (!bl0 && bl_prev) bl_len <= cyc - bl_rise;
            if (use_const && {r0, g0, b0} != (bl0 ? 24'hFF8001 : 24'h0)) rgb_bad <= rgb_bad + 1;
            hs_prev <= hs0;
            bl_prev <= bl0;
        end

    // independent raster model of the short-frame, PIPE_LAT=4 instance: pins show position cyc-5
    function automatic logic [26:0] model4(input int c);
        int p, h, v;
        logic vis;
        p = c - 5;
        if (p < 0) return {3'b110, 24'h0};
        h = p % 800;
        v = (p / 800) % 10;
        vis = h < 640 && v < 4;
        return {!(h >= 656 && h < 752), !(v >= 6 && v < 8), vis, vis ? colf(19'(v * 640 + h)) : 24'h0};
    endfunction

    always @(negedge clk)
        if (rst4_n) begin
            if ({hs4, vs4, bl4, r4, g4, b4} != model4(cyc4)) mbad <= mbad + 1;
            if (!vs4 && vs_prev) vs_fall <= cyc4;
            if (vs4 && !vs_prev) vs_len <= cyc4 - vs_fall;
            vs_prev <= vs4;
            if (fs4) begin
                if (fs_last >= 0) fs_per <= cyc4 - fs_last;
                fs_last <= cyc4;
                fs_cnt  <= fs_cnt + 1;
            end
            if (int'(addr4) > amax) amax <= int'(addr4);
        end

    function automatic int probe(input bit d, input sig_e s);
        if (!d)
            case (s)
                S_ADDR:   return int'(addr0);
                S_HS:     return int'(hs0);
                S_VS:     return int'(vs0);
                S_BLANK:  return int'(bl0);
                S_RGB:    return int'({r0, g0, b0});
                S_FS:     return int'(fs0);
                S_HSFALL: return hs_fall;
                S_HSLEN:  return hs_len;
                S_BLEN:   return bl_len;
                S_RGBBAD: return rgb_bad;
                default:  return -1;
            endcase
        case (s)
            S_ADDR:   return int'(addr4);
            S_FS:     return int'(fs4);
            S_VSFALL: return vs_fall;
            S_VSLEN:  return vs_len;
            S_FSPER:  return fs_per;
            S_FSCNT:  return fs_cnt;
            S_AMAX:   return amax;
            S_MBAD:   return mbad;
            default:  return -1;
        endcase
    endfunction

    function automatic void add(input bit d, input int c, input sig_e s, input int v, input string n);
        q.push_back('{d: d, cyc: c, s: s, val: v, name: n});
    endfunction

    // monitor: pops every due expectation and compares it with what the pins show now
    initial forever begin
        int i;
        @(negedge clk);
        i = 0;
        while (i < q.size()) begin
            automatic int c = q[i].d ? cyc4 : cyc;
            automatic bit live = q[i].d ? rst4_n : rst_n;
            if (live && q[i].cyc <= c) begin
                automatic int act = probe(q[i].d, q[i].s);
                nchk++;
                if (q[i].cyc < c) begin
                    nfail++;
                    $display("FAIL %s: due at cycle %0d, first seen at %0d", q[i].name, q[i].cyc, c);
                end else if (act != q[i].val) begin
                    nfail++;
                    $display("FAIL %s @%0d: got 0x%0h, expected 0x%0h", q[i].name, c, act, q[i].val);
                end
                q.delete(i);
            end else i++;
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        add(0, 0, S_ADDR, 0, "rst_addr");      add(0, 0, S_HS, 1, "rst_hs");
        add(0, 0, S_VS, 1, "rst_vs");          add(0, 0, S_BLANK, 0, "rst_blank");
        add(0, 0, S_RGB, 0, "rst_rgb");        add(0, 0, S_FS, 0, "rst_fs");
        add(0, 2, S_BLANK, 0, "blank_c2");     add(0, 3, S_BLANK, 1, "blank_c3");
        add(0, 3, S_RGB, 'h00FF00, "rgb_a0");  add(0, 639, S_ADDR, 639, "addr_639_0");
        add(0, 640, S_ADDR, 640, "addr_640_0"); add(0, 799, S_ADDR, 640, "addr_799_0");
        add(0, 800, S_ADDR, 640, "addr_0_1");  add(0, 1000, S_ADDR, 840, "addr_200_1");
        add(0, 642, S_RGB, 'h7F8002, "rgb_a639"); add(0, 643, S_BLANK, 0, "blank_c643");
        add(0, 643, S_RGB, 0, "rgb_hblank");   add(0, 803, S_BLANK, 1, "blank_line1");
        add(0, 803, S_RGB, 'h807F02, "rgb_a640");
        add(0, 658, S_HS, 1, "hs_c658");       add(0, 659, S_HS, 0, "hs_c659");
        add(0, 754, S_HS, 0, "hs_c754");       add(0, 755, S_HS, 1, "hs_c755");
        add(0, 700, S_BLEN, 640, "blank_len"); add(0, 1500, S_HSFALL, 1459, "hs_period");
        add(0, 1600, S_HSLEN, 96, "hs_len");
        add(1, 0, S_ADDR, 0, "s_addr0");       add(1, 639, S_ADDR, 639, "s_addr639");
        add(1, 3039, S_ADDR, 2559, "s_addr_last"); add(1, 3040, S_ADDR, 0, "s_addr_hb_last");
        add(1, 3199, S_FS, 0, "s_fs_before");  add(1, 3200, S_FS, 1, "s_fs");
        add(1, 3200, S_ADDR, 0, "s_addr_vblank"); add(1, 3201, S_FS, 0, "s_fs_after");
        add(1, 7000, S_VSFALL, 4805, "s_vs_start"); add(1, 7000, S_VSLEN, 1600, "s_vs_len");
        add(1, 8000, S_ADDR, 0, "s_addr_f2");  add(1, 8005, S_ADDR, 5, "s_addr_f2_5");
        add(1, 11200, S_FS, 1, "s_fs2");       add(1, 20000, S_FSPER, 8000, "s_fs_period");
        add(1, 20000, S_FSCNT, 3, "s_fs_count"); add(1, 24000, S_AMAX, 2559, "s_addr_max");
        add(1, 24000, S_MBAD, 0, "s_model_mismatches");
        rst_n = 1;
        rst4_n = 1;
        repeat (2300) @(posedge clk);
        #1;
        rst_n = 0;
        use_const = 1;
        @(posedge clk);
        #1;
        rst_n = 1;
        add(0, 0, S_ADDR, 0, "mid_addr");      add(0, 0, S_HS, 1, "mid_hs");
        add(0, 0, S_VS, 1, "mid_vs");          add(0, 0, S_BLANK, 0, "mid_blank");
        add(0, 0, S_RGB, 0, "mid_rgb");        add(0, 3, S_BLANK, 1, "mid_blank_c3");
        add(0, 3, S_RGB, 'hFF8001, "const_rgb"); add(0, 642, S_RGB, 'hFF8001, "const_rgb_end");
        add(0, 643, S_RGB, 0, "const_rgb_hblank"); add(0, 700, S_HSFALL, 659, "mid_hs_start");
        add(0, 760, S_HSLEN, 96, "mid_hs_len"); add(0, 1700, S_BLEN, 640, "mid_blank_len");
        add(0, 1700, S_RGBBAD, 0, "const_rgb_violations");
        for (int k = 0; k < 30000 && cyc4 < 24010; k++) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        foreach (q[j]) begin
            nchk++;
            nfail++;
            $display("FAIL %s: never reached (due cycle %0d)", q[j].name, q[j].cyc);
        end
        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end
endmodule
